// File: rtl/fetch.sv
// Instruction fetch stage: drives instruction-memory port 0 and tracks two in-flight read slots so that
// pc_out/bubble_out line up with mem_out_0. Optional `FETCH_PERF_EN adds the fetch_bubble_count port.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr_0,
  output logic        mem_re_0,
  output logic [31:0] pc_out,
  output logic        bubble_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_bubble_count
`endif
);

  logic [31:0] fetch_pc;
  logic [31:0] pc1;
  logic        v1;

  logic        advance;
  logic        take_redirect;
  logic [31:0] redirect_aligned;

  assign advance          = !halt && !stall && !redirect;
  assign take_redirect    = !halt && redirect;
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  assign mem_addr_0 = fetch_pc;
  assign mem_re_0   = !rst && !halt && !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (take_redirect) begin
      fetch_pc <= redirect_aligned;
    end else if (advance) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // A redirect squashes slot 1 and the output slot; the word already in slot 1 becomes the second bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc1        <= '0;
      v1         <= 1'b0;
      pc_out     <= '0;
      bubble_out <= 1'b1;
    end else if (take_redirect) begin
      v1         <= 1'b0;
      bubble_out <= 1'b1;
    end else if (advance) begin
      pc1        <= fetch_pc;
      v1         <= 1'b1;
      pc_out     <= pc1;
      bubble_out <= !v1;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_bubble_count <= '0;
    end else if (!halt && !stall && bubble_out) begin
      fetch_bubble_count <= fetch_bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch.sv
// Directed, table-driven bench for the fetch stage: startup, stall, redirect, halt, wrap and async reset.
module tb_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        halt;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr_0;
  logic        mem_re_0;
  logic [31:0] pc_out;
  logic        bubble_out;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_bubble_count;
`endif

  int checks;
  int failures;

  fetch #(.RESET_PC(32'h0000_0400)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .halt       (halt),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_addr_0 (mem_addr_0),
    .mem_re_0   (mem_re_0),
    .pc_out     (pc_out),
    .bubble_out (bubble_out)
`ifdef FETCH_PERF_EN
    ,
    .fetch_bubble_count(fetch_bubble_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row per clock edge: inputs, address/enable seen before the edge, pc/bubble seen after it.
  typedef struct {
    logic        st;
    logic        hl;
    logic        rd;
    logic [31:0] rpc;
    logic [31:0] addr;
    logic        re;
    logic [31:0] pc;
    logic        bub;
  } vec_t;

  localparam int unsigned NV = 32;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic st, input logic hl, input logic rd, input logic [31:0] rpc,
                              input logic [31:0] addr, input logic re, input logic [31:0] pc,
                              input logic bub);
    vec_t v;
    v.st = st; v.hl = hl; v.rd = rd; v.rpc = rpc;
    v.addr = addr; v.re = re; v.pc = pc; v.bub = bub;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input string tag, input vec_t v);
    @(negedge clk);
    stall = v.st; halt = v.hl; redirect = v.rd; redirect_pc = v.rpc;
    #1;
    chk({tag, " mem_addr_0"}, mem_addr_0, v.addr);
    chk({tag, " mem_re_0"}, {31'd0, mem_re_0}, {31'd0, v.re});
    @(posedge clk);
    #1;
    chk({tag, " pc_out"}, pc_out, v.pc);
    chk({tag, " bubble_out"}, {31'd0, bubble_out}, {31'd0, v.bub});
  endtask

  int exp_cnt;
  logic prev_bub;

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; stall = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;

    //            st  hl  rd  rpc            addr           re  pc             bub
    tbl[0]  = mk(0, 0, 0, 32'h0,         32'h400,       1, 32'h0,         1);
    tbl[1]  = mk(0, 0, 0, 32'h0,         32'h404,       1, 32'h400,       0);
    tbl[2]  = mk(0, 0, 0, 32'h0,         32'h408,       1, 32'h404,       0);
    tbl[3]  = mk(0, 0, 0, 32'h0,         32'h40C,       1, 32'h408,       0);
    tbl[4]  = mk(1, 0, 0, 32'h0,         32'h410,       0, 32'h408,       0);
    tbl[5]  = mk(1, 0, 0, 32'h0,         32'h410,       0, 32'h408,       0);
    tbl[6]  = mk(1, 0, 0, 32'h0,         32'h410,       0, 32'h408,       0);
    tbl[7]  = mk(0, 0, 0, 32'h0,         32'h410,       1, 32'h40C,       0);
    tbl[8]  = mk(0, 0, 0, 32'h0,         32'h414,       1, 32'h410,       0);
    tbl[9]  = mk(0, 0, 0, 32'h0,         32'h418,       1, 32'h414,       0);
    tbl[10] = mk(0, 0, 0, 32'h0,         32'h41C,       1, 32'h418,       0);
    tbl[11] = mk(0, 0, 1, 32'h1003,      32'h420,       1, 32'h418,       1);
    tbl[12] = mk(0, 0, 0, 32'h0,         32'h1000,      1, 32'h41C,       1);
    tbl[13] = mk(0, 0, 0, 32'h0,         32'h1004,      1, 32'h1000,      0);
    tbl[14] = mk(0, 0, 0, 32'h0,         32'h1008,      1, 32'h1004,      0);
    tbl[15] = mk(1, 0, 1, 32'h2000,      32'h100C,      0, 32'h1004,      1);
    tbl[16] = mk(0, 0, 0, 32'h0,         32'h2000,      1, 32'h1008,      1);
    tbl[17] = mk(0, 0, 0, 32'h0,         32'h2004,      1, 32'h2000,      0);
    tbl[18] = mk(0, 0, 0, 32'h0,         32'h2008,      1, 32'h2004,      0);
    tbl[19] = mk(0, 1, 1, 32'h3000,      32'h200C,      0, 32'h2004,      0);
    tbl[20] = mk(1, 1, 0, 32'h0,         32'h200C,      0, 32'h2004,      0);
    tbl[21] = mk(0, 0, 0, 32'h0,         32'h200C,      1, 32'h2008,      0);
    tbl[22] = mk(0, 0, 0, 32'h0,         32'h2010,      1, 32'h200C,      0);
    tbl[23] = mk(0, 0, 1, 32'h5000,      32'h2014,      1, 32'h200C,      1);
    tbl[24] = mk(0, 0, 1, 32'h6004,      32'h5000,      1, 32'h200C,      1);
    tbl[25] = mk(0, 0, 0, 32'h0,         32'h6004,      1, 32'h2010,      1);
    tbl[26] = mk(0, 0, 0, 32'h0,         32'h6008,      1, 32'h6004,      0);
    tbl[27] = mk(0, 0, 1, 32'hFFFF_FFF9, 32'h600C,      1, 32'h6004,      1);
    tbl[28] = mk(0, 0, 0, 32'h0,         32'hFFFF_FFF8, 1, 32'h6008,      1);
    tbl[29] = mk(0, 0, 0, 32'h0,         32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 0);
    tbl[30] = mk(0, 0, 0, 32'h0,         32'h0,         1, 32'hFFFF_FFFC, 0);
    tbl[31] = mk(0, 0, 0, 32'h0,         32'h4,         1, 32'h0,         0);

    #2;
    chk("reset pc_out", pc_out, 32'h0);
    chk("reset bubble_out", {31'd0, bubble_out}, 32'd1);
    chk("reset mem_addr_0", mem_addr_0, 32'h400);
    chk("reset mem_re_0", {31'd0, mem_re_0}, 32'd0);
`ifdef FETCH_PERF_EN
    chk("reset bubble_count", fetch_bubble_count, 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    exp_cnt = 0;
    prev_bub = 1'b1;
    for (int i = 0; i < int'(NV); i++) begin
      step($sformatf("row%0d", i), tbl[i]);
      if (!tbl[i].st && !tbl[i].hl && prev_bub) exp_cnt++;
      prev_bub = tbl[i].bub;
    end
`ifdef FETCH_PERF_EN
    chk("bubble_count table", fetch_bubble_count, exp_cnt);
`endif

    // Asynchronous reset between edges, then restart from RESET_PC.
    @(negedge clk);
    stall = 1'b0; halt = 1'b0; redirect = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("async rst pc_out", pc_out, 32'h0);
    chk("async rst bubble_out", {31'd0, bubble_out}, 32'd1);
    chk("async rst mem_addr_0", mem_addr_0, 32'h400);
    chk("async rst mem_re_0", {31'd0, mem_re_0}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst held bubble_out", {31'd0, bubble_out}, 32'd1);
    rst = 1'b0;
    step("restart0", mk(0, 0, 0, 32'h0, 32'h400, 1, 32'h0,   1));
    step("restart1", mk(0, 0, 0, 32'h0, 32'h404, 1, 32'h400, 0));
    step("restart2", mk(0, 0, 0, 32'h0, 32'h408, 1, 32'h404, 0));
`ifdef FETCH_PERF_EN
    chk("bubble_count restart", fetch_bubble_count, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
